data_cache: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the CPU's load/store path and the 32-bit-block data memory.
- Its `readdata` output feeds the writeback 2-to-1 select, alongside the ALU result.
- Stalls the CPU through `busywait` on misses, and runs block fetch and dirty-block eviction against memory.
- Geometry: 8 lines × 4 bytes; 8-bit byte address split as tag[7:5], index[4:2], offset[1:0].

---
 rtl/cache_pkg.sv | 15 +
 rtl/dcache_line_store.sv | 52 +++++
 rtl/data_cache.sv | 113 +++++++++++
 tb/tb_data_cache.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and geometry for the direct-mapped data cache.
package cache_pkg;
  localparam int TAG_W   = 3;
  localparam int IDX_W   = 3;
  localparam int OFF_W   = 2;
  localparam int BLOCK_W = 32;
  localparam int LINES   = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2,
    UPDATE    = 2'd3
  } state_t;
endpackage

// File: rtl/dcache_line_store.sv
// Valid/dirty/tag/data arrays for the data cache. One line is selected by
// i_idx; it can take a single-byte store or a whole-block fill per cycle.
module dcache_line_store
  import cache_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [IDX_W-1:0]   i_idx,
  input  logic               i_byte_we,
  input  logic [OFF_W-1:0]   i_off,
  input  logic [7:0]         i_byte,
  input  logic               i_fill_we,
  input  logic [TAG_W-1:0]   i_fill_tag,
  input  logic [BLOCK_W-1:0] i_fill_data,
  output logic               o_valid,
  output logic               o_dirty,
  output logic [TAG_W-1:0]   o_tag,
  output logic [BLOCK_W-1:0] o_data
);
  logic [LINES-1:0]   r_valid;
  logic [LINES-1:0]   r_dirty;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [BLOCK_W-1:0] r_data [LINES];

  // Line status bits: cleared on reset, set by a fill, dirtied by a store.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_we) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_byte_we) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end

  // Tag and data storage; contents are meaningless until the line is valid.
  always_ff @(posedge i_clk) begin
    if (i_fill_we) begin
      r_tag[i_idx]  <= i_fill_tag;
      r_data[i_idx] <= i_fill_data;
    end else if (i_byte_we) begin
      r_data[i_idx][8*i_off +: 8] <= i_byte;
    end
  end

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_data  = r_data[i_idx];
endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache. Hits complete with no
// stall; misses run an optional dirty-block eviction, then a block fetch.
module data_cache
  import cache_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
);
  state_t             r_state;
  logic               r_mem_read;
  logic               r_mem_write;
  logic [5:0]         r_mem_addr;

  logic [TAG_W-1:0]   w_tag;
  logic [IDX_W-1:0]   w_idx;
  logic [OFF_W-1:0]   w_off;
  logic               w_req;
  logic               w_valid;
  logic               w_dirty;
  logic [TAG_W-1:0]   w_line_tag;
  logic [BLOCK_W-1:0] w_data;
  logic               w_hit;
  logic               w_idle_hit;

  assign w_tag      = address[7:5];
  assign w_idx      = address[4:2];
  assign w_off      = address[1:0];
  assign w_req      = read | write;
  assign w_hit      = w_valid && (w_line_tag == w_tag);
  assign w_idle_hit = (r_state == IDLE) && w_hit;

  dcache_line_store u_store (
    .i_clk       (CLK),
    .i_rst       (RESET),
    .i_idx       (w_idx),
    .i_byte_we   (w_idle_hit && write),
    .i_off       (w_off),
    .i_byte      (writedata),
    .i_fill_we   (r_state == UPDATE),
    .i_fill_tag  (w_tag),
    .i_fill_data (mem_readdata),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty),
    .o_tag       (w_line_tag),
    .o_data      (w_data)
  );

  // Miss handler: memory request strobes and block address are registered
  // alongside the state so they are stable for the whole request.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && !w_hit) begin
            if (w_valid && w_dirty) begin
              r_state     <= MEM_WRITE;
              r_mem_write <= 1'b1;
              r_mem_addr  <= {w_line_tag, w_idx};
            end else begin
              r_state    <= MEM_READ;
              r_mem_read <= 1'b1;
              r_mem_addr <= {w_tag, w_idx};
            end
          end
        end
        MEM_WRITE: begin
          if (!mem_busywait) begin
            r_state     <= MEM_READ;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b1;
            r_mem_addr  <= {w_tag, w_idx};
          end
        end
        MEM_READ: begin
          if (!mem_busywait) begin
            r_state    <= UPDATE;
            r_mem_read <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Load data is only driven for a hit in IDLE; zero otherwise (and in reset).
  always_comb begin
    readdata = 8'h00;
    if (w_idle_hit) readdata = w_data[8*w_off +: 8];
  end

  assign busywait      = w_req && !w_idle_hit;
  assign mem_read      = r_mem_read;
  assign mem_write     = r_mem_write;
  assign mem_address   = r_mem_addr;
  assign mem_writedata = w_data;
endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: directed vector table, reset/idle corner cases, and
// randomized accesses checked against a byte-level memory-image model.
module tb_data_cache;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [7:0]  address = 8'h00;
  logic [7:0]  writedata = 8'h00;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = 32'h0;
  logic        mem_busywait = 1'b0;

  int total = 0;
  int bad = 0;

  data_cache dut (
    .CLK(CLK), .RESET(RESET), .read(read), .write(write), .address(address),
    .writedata(writedata), .readdata(readdata), .busywait(busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait)
  );

  always #5 CLK = ~CLK;

  // ---------------- memory model: 4 busy cycles per request ----------------
  logic [31:0] mem [64];
  int          cnt = 0;
  logic [1:0]  last_kind = 2'b00;
  int          n_rd = 0;
  int          n_wr = 0;
  logic [5:0]  last_rd_addr = '0;
  logic [5:0]  last_wb_addr = '0;
  logic [31:0] last_wb_data = '0;
  int          rdcnt [64];
  int          n_conflict = 0;

  always @(negedge CLK) begin
    logic [1:0] kind;
    kind = {mem_read, mem_write};
    if (kind != last_kind) cnt = 0;
    last_kind = kind;
    if (kind == 2'b00) begin
      mem_busywait = 1'b0;
    end else if (cnt < 4) begin
      mem_busywait = 1'b1;
      cnt++;
    end else if (mem_busywait) begin
      mem_busywait = 1'b0;
      if (mem_read) begin
        mem_readdata = mem[mem_address];
        n_rd++;
        last_rd_addr = mem_address;
        rdcnt[mem_address]++;
      end else begin
        mem[mem_address] = mem_writedata;
        n_wr++;
        last_wb_addr = mem_address;
        last_wb_data = mem_writedata;
      end
    end
  end

  always @(negedge CLK) if (read && write) n_conflict++;

  // ---------------- reference model: CPU-visible bytes + residency ----------
  logic [7:0] golden [256];
  logic       m_valid [8];
  logic       m_dirty [8];
  logic [2:0] m_tag [8];

  task automatic model_reset();
    for (int b = 0; b < 64; b++)
      for (int o = 0; o < 4; o++) golden[b*4+o] = mem[b][8*o +: 8];
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = 3'd0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One CPU request held until busywait drops (bounded).
  task automatic access(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d,
                        output logic hit, output logic [7:0] rdat, output logic tmo,
                        output int drd, output int dwr);
    int r0, w0, k;
    r0 = n_rd;
    w0 = n_wr;
    @(posedge CLK); #1;
    read = r; write = w; address = a; writedata = d;
    @(negedge CLK);
    hit = !busywait;
    tmo = 1'b0;
    k = 0;
    while (busywait && !tmo) begin
      @(negedge CLK);
      k++;
      if (k > 200) tmo = 1'b1;
    end
    rdat = readdata;
    drd = n_rd - r0;
    dwr = n_wr - w0;
  endtask

  task automatic go_idle();
    @(posedge CLK); #1;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic do_reset();
    go_idle();
    @(negedge CLK); RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0;
    model_reset();
  endtask

  task automatic run_model(input logic r, input logic w, input logic [7:0] a,
                           input logic [7:0] d, input string nm);
    logic [2:0] idx, t, ot;
    logic eh, ev, hit, tmo;
    logic [7:0] rdat;
    logic [31:0] evd;
    int drd, dwr;
    idx = a[4:2];
    t   = a[7:5];
    ot  = m_tag[idx];
    eh  = m_valid[idx] && (ot == t);
    ev  = !eh && m_valid[idx] && m_dirty[idx];
    evd = {golden[{ot, idx, 2'd3}], golden[{ot, idx, 2'd2}],
           golden[{ot, idx, 2'd1}], golden[{ot, idx, 2'd0}]};
    access(r, w, a, d, hit, rdat, tmo, drd, dwr);
    chk({nm, "_timeout"}, tmo, 0);
    chk({nm, "_hit"}, hit, eh);
    chk({nm, "_fills"}, drd, eh ? 0 : 1);
    chk({nm, "_evicts"}, dwr, ev ? 1 : 0);
    if (ev && dwr == 1) begin
      chk({nm, "_wb_addr"}, last_wb_addr, {ot, idx});
      chk({nm, "_wb_data"}, last_wb_data, evd);
    end
    if (r && !w) chk({nm, "_rdata"}, rdat, golden[a]);
    if (!eh) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = t;
      m_dirty[idx] = 1'b0;
    end
    if (w) begin
      golden[a]    = d;
      m_dirty[idx] = 1'b1;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r, w;
    logic [7:0]  a, d;
    logic        ehit;
    logic [7:0]  erd;
    int          efill;
    logic [5:0]  efill_addr;
    int          ewb;
    logic [5:0]  ewb_addr;
    logic [31:0] ewb_data;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hit, tmo;
    logic [7:0] rdat;
    int drd, dwr, k;

    for (int b = 0; b < 64; b++) begin
      mem[b] = $urandom;
      rdcnt[b] = 0;
    end
    mem[1] = 32'h44332211;
    mem[9] = 32'h88776655;

    tbl[0] = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 8'h22, 1, 6'h01, 0, 6'h00, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 8'h06, 8'hAB, 1'b1, 8'h00, 0, 6'h00, 0, 6'h00, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 8'h06, 8'h00, 1'b1, 8'hAB, 0, 6'h00, 0, 6'h00, 32'h0};
    tbl[3] = '{1'b1, 1'b0, 8'h25, 8'h00, 1'b0, 8'h66, 1, 6'h09, 1, 6'h01, 32'h44AB2211};
    tbl[4] = '{1'b1, 1'b0, 8'h06, 8'h00, 1'b0, 8'hAB, 1, 6'h01, 0, 6'h00, 32'h0};

    // reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busywait", busywait, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_readdata", readdata, 0);
    @(negedge CLK) RESET = 1'b0;

    // directed table
    for (int i = 0; i < 5; i++) begin
      access(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, hit, rdat, tmo, drd, dwr);
      chk($sformatf("vec%0d_timeout", i), tmo, 0);
      chk($sformatf("vec%0d_hit", i), hit, tbl[i].ehit);
      chk($sformatf("vec%0d_fills", i), drd, tbl[i].efill);
      chk($sformatf("vec%0d_evicts", i), dwr, tbl[i].ewb);
      if (tbl[i].r) chk($sformatf("vec%0d_rdata", i), rdat, tbl[i].erd);
      if (tbl[i].efill == 1) chk($sformatf("vec%0d_fill_addr", i), last_rd_addr, tbl[i].efill_addr);
      if (tbl[i].ewb == 1) begin
        chk($sformatf("vec%0d_wb_addr", i), last_wb_addr, tbl[i].ewb_addr);
        chk($sformatf("vec%0d_wb_data", i), last_wb_data, tbl[i].ewb_data);
      end
    end
    go_idle();

    // no request: no stall and no memory traffic
    k = n_rd + n_wr;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      address = 8'($urandom);
      writedata = 8'($urandom);
      @(negedge CLK);
      chk("idle_busywait", busywait, 0);
      chk("idle_mem_req", {mem_read, mem_write}, 0);
    end
    chk("idle_traffic", n_rd + n_wr, k);

    // sequential sweep 0x00-0x1F: one fill per line
    do_reset();
    for (int b = 0; b < 64; b++) rdcnt[b] = 0;
    for (int a = 0; a < 32; a++) run_model(1'b1, 1'b0, 8'(a), 8'h00, "sweep");
    for (int b = 0; b < 8; b++) chk($sformatf("sweep_fills_line%0d", b), rdcnt[b], 1);

    // reset while the block fetch is waiting
    do_reset();
    @(posedge CLK); #1;
    read = 1'b1; address = 8'h05;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!mem_read && k < 50);
    chk("midrst_req_seen", mem_read, 1);
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("midrst_mem_read", mem_read, 0);
    chk("midrst_mem_write", mem_write, 0);
    read = 1'b0;
    @(negedge CLK) RESET = 1'b0;
    model_reset();
    run_model(1'b1, 1'b0, 8'h05, 8'h00, "postrst");

    // randomized loads and stores
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic r;
      r = 1'($urandom);
      run_model(r, !r, 8'($urandom), 8'($urandom), $sformatf("rnd%0d", i));
    end
    go_idle();

    chk("conflicting_requests", n_conflict, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
